adc0809_emu: RTL and testbench
==============================

Name: adc0809_emu

Overview:
- Synthesizable responder model of an ADC0809-style 8-channel, 8-bit successive-approximation converter.
- Answers the controller side of the ale/start/eoc/out_en/adc_clk handshake: latches the channel address, runs a timed conversion and signals completion on eoc.
- Drives the selected channel's sample onto result while out_en is high.
- Used on-board and in benches so ADC controller logic can be exercised without the physical chip. Channel values come from ch_data, e.g. switches or a test pattern.

Parameters:
- CONV_CYCLES, 64: adc_clk rising edges from conversion start to end of conversion. Legal range 1..65535.
- EOC_LAT, 2: clk cycles from start-rise detection to eoc falling. Legal range 0..255.

Ports:
- clk  input  1  system clock; all logic is in this domain.
- reset  input  1  asynchronous, active-low reset.
- adc_clk  input  1  converter clock from the controller; sampled on clk and edge-detected.
- ale  input  1  address latch enable; rising edge latches addr.
- addr  input  3  channel select.
- start  input  1  conversion start; rising edge resets, falling edge begins conversion.
- out_en  input  1  output enable.
- ch_data  input  64  analog stand-ins; channel n = ch_data[8n+7:8n].
- eoc  output  1  end of conversion: high = idle/done, low = converting.
- result  output  8  out_en ? result_reg : 8'h00 (combinational).

Behaviour:
- Edge detection:
  - Register start_q, ale_q and adc_clk_q every clk.
  - rise = x & ~x_q; fall = ~x & x_q. Detection occurs in the cycle the input first shows the new level.
- Reset (async, reset=0):
  - state=IDLE, eoc=1, result_reg=0, addr_lat=0, sample=0, lat_cnt=0, conv_cnt=0, edge registers=0.
  - result therefore reads 0 regardless of out_en.
- ALE:
  - On ale rise, addr_lat<=addr in any state, including mid-conversion.
  - A rise during CONV does not affect the running conversion, which already holds its sample.
- States: IDLE, SAR_RST, CONV.
- IDLE:
  - eoc=1.
  - start rise -> SAR_RST, lat_cnt<=0.
- SAR_RST (start held high):
  - lat_cnt increments each clk. When lat_cnt==EOC_LAT, eoc<=0.
  - With EOC_LAT=0, eoc falls on the first clk edge after the rise is detected.
  - start fall -> CONV: eoc<=0 forced even if EOC_LAT has not elapsed; sample<=ch_data[addr_lat]; conv_cnt<=0.
- CONV:
  - Each adc_clk rise increments conv_cnt.
  - On the adc_clk rise that makes conv_cnt reach CONV_CYCLES: result_reg<=sample, eoc<=1, state<=IDLE, all on the same clk edge.
  - start rise -> abort: state<=SAR_RST, lat_cnt<=0, eoc stays 0, result_reg retains its previous value.
  - start rise and adc_clk rise in the same cycle: the start rise wins and the adc_clk edge is ignored.
- Sampling point:
  - ch_data is captured only at start-fall detection.
  - Later ch_data or addr changes do not alter that conversion.
- out_en:
  - Purely gates the output. No effect on state.
  - result_reg persists until the next completed conversion.
  - out_en high during CONV shows the previous result.
- eoc:
  - Registered, glitch-free.
  - Never low while in IDLE; never high in CONV.
- Counter widths: conv_cnt 16 bits, lat_cnt 8 bits. Both saturate (never wrap) while waiting.

Test Plan:
- Reset: assert reset with out_en=1 -> eoc=1, result=8'h00; still 1 and 0 for 100 clk after release with no stimulus.
- Normal conversion (adc_clk period 54 clk, ch3=8'hA5):
  - Stimulus: ale pulse with addr=3, then start high for 8 clk.
  - eoc falls exactly 2 clk after start-rise detection.
  - eoc rises on the 64th adc_clk rise after start fall.
  - out_en=1 -> result=8'hA5; out_en=0 -> result=8'h00.
- Sample hold: change ch3 to 8'h11 one cycle after start fall -> completed result still 8'hA5. A following conversion returns 8'h11.
- Short start: 1-clk start pulse with EOC_LAT=2 -> eoc falls on start-fall detection, not later; conversion completes normally.
- Abort/restart:
  - Second start pulse after 20 adc_clk rises, with ch0=8'h3C and addr_lat=0 via a new ale -> eoc never rises between conversions.
  - eoc rises 64 adc_clk rises after the second start fall; result=8'h3C.
  - Before that, result_reg still holds 8'hA5.
- Reset mid-conversion: assert reset at adc_clk rise 30 -> eoc=1, result=8'h00 immediately. A subsequent full conversion works from IDLE.

Source files
------------

// File: rtl/adc0809_emu.sv
// rtl/adc0809_emu.sv - ADC0809-style 8-channel 8-bit converter responder model
//
// Purpose: answers the controller side of the ale/start/eoc/out_en/adc_clk
// handshake. Latches the channel on ale rise and samples that channel on the
// start fall. It then counts CONV_CYCLES adc_clk rises and publishes the sample.
//
// Ports:
//   clk      in   1  system clock, all logic in this domain
//   reset    in   1  asynchronous active-low reset
//   adc_clk  in   1  converter clock from the controller (edge-detected on clk)
//   ale      in   1  address latch enable, rising edge latches addr
//   addr     in   3  channel select
//   start    in   1  rise resets the SAR, fall begins the conversion
//   out_en   in   1  output enable for result
//   ch_data  in  64  channel n = ch_data[8n+7:8n]
//   eoc      out  1  high = idle/done, low = converting
//   result   out  8  out_en ? last completed result : 8'h00

module adc0809_emu #(
    parameter int CONV_CYCLES = 64,
    parameter int EOC_LAT     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_clk,
    input  logic        ale,
    input  logic [2:0]  addr,
    input  logic        start,
    input  logic        out_en,
    input  logic [63:0] ch_data,
    output logic        eoc,
    output logic [7:0]  result
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAR_RST = 2'd1,
        S_CONV    = 2'd2
    } state_t;

    localparam logic [16:0] C_CONV = 17'(CONV_CYCLES);
    localparam logic [8:0]  C_LAT  = 9'(EOC_LAT);

    state_t      r_state;
    logic        r_eoc;
    logic [7:0]  r_result;
    logic [2:0]  r_addr_lat;
    logic [7:0]  r_sample;
    logic [7:0]  r_lat_cnt;
    logic [15:0] r_conv_cnt;
    logic        r_start_q;
    logic        r_ale_q;
    logic        r_adc_clk_q;

    logic        w_start_rise;
    logic        w_start_fall;
    logic        w_ale_rise;
    logic        w_adc_rise;
    logic [8:0]  w_lat_next;
    logic [16:0] w_conv_next;

    assign w_start_rise = start & ~r_start_q;
    assign w_start_fall = ~start & r_start_q;
    assign w_ale_rise   = ale & ~r_ale_q;
    assign w_adc_rise   = adc_clk & ~r_adc_clk_q;

    // Extra bit so the "reached" compares stay correct at the saturation limit.
    assign w_lat_next  = {1'b0, r_lat_cnt} + 9'd1;
    assign w_conv_next = {1'b0, r_conv_cnt} + 17'd1;

    assign eoc    = r_eoc;
    assign result = out_en ? r_result : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_eoc       <= 1'b1;
            r_result    <= 8'h00;
            r_addr_lat  <= 3'd0;
            r_sample    <= 8'h00;
            r_lat_cnt   <= 8'd0;
            r_conv_cnt  <= 16'd0;
            r_start_q   <= 1'b0;
            r_ale_q     <= 1'b0;
            r_adc_clk_q <= 1'b0;
        end else begin
            r_start_q   <= start;
            r_ale_q     <= ale;
            r_adc_clk_q <= adc_clk;

            // A mid-conversion ale only affects the next conversion; the
            // running one already holds its sample.
            if (w_ale_rise) begin
                r_addr_lat <= addr;
            end

            case (r_state)
                S_IDLE: begin
                    r_eoc <= 1'b1;
                    if (w_start_rise) begin
                        r_state   <= S_SAR_RST;
                        r_lat_cnt <= 8'd0;
                    end
                end

                S_SAR_RST: begin
                    if (w_start_fall) begin
                        r_state    <= S_CONV;
                        r_eoc      <= 1'b0;
                        r_sample   <= ch_data[{r_addr_lat, 3'b000} +: 8];
                        r_conv_cnt <= 16'd0;
                    end else begin
                        // Compare the post-increment count so eoc drops EOC_LAT
                        // edges after detection, but never earlier than one edge.
                        if (w_lat_next >= C_LAT) begin
                            r_eoc <= 1'b0;
                        end
                        if (r_lat_cnt != 8'hFF) begin
                            r_lat_cnt <= w_lat_next[7:0];
                        end
                    end
                end

                S_CONV: begin
                    // Restart has priority over a coincident adc_clk edge.
                    if (w_start_rise) begin
                        r_state   <= S_SAR_RST;
                        r_lat_cnt <= 8'd0;
                    end else if (w_adc_rise) begin
                        if (w_conv_next >= C_CONV) begin
                            r_result <= r_sample;
                            r_eoc    <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                        if (r_conv_cnt != 16'hFFFF) begin
                            r_conv_cnt <= w_conv_next[15:0];
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_eoc   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc0809_emu.sv
// tb/tb_adc0809_emu.sv - self-checking bench for adc0809_emu

module tb_adc0809_emu;

    localparam int CONV     = 64;
    localparam int LAT      = 2;
    localparam int ADC_HALF = 27;
    localparam int LAT_EFF  = (LAT < 1) ? 1 : LAT;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_clk;
    logic        ale;
    logic [2:0]  addr;
    logic        start;
    logic        out_en;
    logic [63:0] ch_data;
    logic        eoc;
    logic [7:0]  result;

    adc0809_emu #(.CONV_CYCLES(CONV), .EOC_LAT(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .adc_clk (adc_clk),
        .ale     (ale),
        .addr    (addr),
        .start   (start),
        .out_en  (out_en),
        .ch_data (ch_data),
        .eoc     (eoc),
        .result  (result)
    );

    always #5 clk = ~clk;

    int         errs   = 0;
    int         checks = 0;
    int         adc_ph = 0;
    logic       adc_seen = 1'b0;
    logic       adc_prev = 1'b0;
    logic [7:0] ch [8];
    logic [2:0] m_addr   = 3'd0;
    logic [7:0] m_result = 8'h00;
    logic [7:0] m_sample = 8'h00;

    task automatic drive_ch();
        for (int i = 0; i < 8; i++) ch_data[8*i +: 8] = ch[i];
    endtask

    // One clk cycle; records the adc_clk level the DUT saw at this edge.
    task automatic tick();
        @(posedge clk);
        adc_prev = adc_seen;
        adc_seen = adc_clk;
        #1;
        adc_ph  = (adc_ph + 1) % (2 * ADC_HALF);
        adc_clk = (adc_ph >= ADC_HALF);
    endtask

    task automatic ale_pulse(input logic [2:0] a);
        addr = a;
        ale  = 1'b1;
        tick();
        ale  = 1'b0;
        tick();
        m_addr = a;
    endtask

    task automatic do_start(input int len, input bit from_conv);
        logic exp_eoc;
        start = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick();
            exp_eoc = from_conv ? 1'b0 : ((i >= LAT_EFF) ? 1'b0 : 1'b1);
            checks++;
            if (eoc !== exp_eoc) begin
                errs++;
                $display("FAIL sar_eoc[%0d]: got %b want %b", i, eoc, exp_eoc);
            end
        end
        start    = 1'b0;
        m_sample = ch[m_addr];
        tick();
        checks++;
        if (eoc !== 1'b0) begin
            errs++;
            $display("FAIL fall_eoc: got %b want 0", eoc);
        end
    endtask

    // Waits for n adc_clk rises after the start fall, checking eoc and the
    // gated result every cycle with a random out_en.
    task automatic conv_wait(input int n, input bit chg_en, input logic [7:0] chg_val);
        int         cnt;
        logic       exp_eoc;
        logic [7:0] exp_res;
        cnt = 0;
        for (int t = 0; t < n * 2 * ADC_HALF + 200 && cnt < n; t++) begin
            tick();
            if (chg_en && t == 0) begin
                ch[m_addr] = chg_val;
                drive_ch();
            end
            if (adc_seen && !adc_prev) cnt++;
            out_en = 1'($urandom);
            #1;
            exp_eoc = (cnt >= CONV);
            exp_res = out_en ? ((cnt >= CONV) ? m_sample : m_result) : 8'h00;
            checks++;
            if (eoc !== exp_eoc) begin
                errs++;
                $display("FAIL conv_eoc rise=%0d: got %b want %b", cnt, eoc, exp_eoc);
            end
            checks++;
            if (result !== exp_res) begin
                errs++;
                $display("FAIL conv_result rise=%0d: got %h want %h", cnt, result, exp_res);
            end
        end
        checks++;
        if (cnt < n) begin
            errs++;
            $display("FAIL conv_timeout: got %0d rises want %0d", cnt, n);
        end
        if (cnt >= CONV) m_result = m_sample;
    endtask

    task automatic check_result(input string name);
        out_en = 1'b1;
        #1;
        checks++;
        if (result !== m_result) begin
            errs++;
            $display("FAIL %s en1: got %h want %h", name, result, m_result);
        end
        out_en = 1'b0;
        #1;
        checks++;
        if (result !== 8'h00) begin
            errs++;
            $display("FAIL %s en0: got %h want 00", name, result);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; out_en = 1'b1; ale = 1'b0; start = 1'b0; addr = 3'd0;
        adc_clk = 1'b0;
        for (int i = 0; i < 8; i++) ch[i] = 8'($urandom);
        drive_ch();
        tick(); tick(); tick();
        checks++;
        if (eoc !== 1'b1 || result !== 8'h00) begin
            errs++;
            $display("FAIL reset_state: got eoc=%b result=%h want 1/00", eoc, result);
        end
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (eoc !== 1'b1 || result !== 8'h00) begin
                errs++;
                $display("FAIL reset_idle[%0d]: got eoc=%b result=%h want 1/00", i, eoc, result);
            end
        end
    endtask

    task automatic test_normal();
        ch[3] = 8'hA5;
        drive_ch();
        ale_pulse(3'd3);
        do_start(8, 1'b0);
        conv_wait(CONV, 1'b0, 8'h00);
        check_result("normal");
    endtask

    task automatic test_sample_hold();
        do_start(8, 1'b0);
        conv_wait(CONV, 1'b1, 8'h11);
        check_result("hold_first");
        do_start(8, 1'b0);
        conv_wait(CONV, 1'b0, 8'h00);
        check_result("hold_second");
    endtask

    task automatic test_short_start();
        ch[5] = 8'($urandom);
        drive_ch();
        ale_pulse(3'd5);
        do_start(1, 1'b0);
        conv_wait(CONV, 1'b0, 8'h00);
        check_result("short");
    endtask

    task automatic test_abort();
        ch[3] = 8'hA5;
        ch[0] = 8'h3C;
        drive_ch();
        ale_pulse(3'd3);
        do_start(8, 1'b0);
        conv_wait(CONV, 1'b0, 8'h00);
        do_start(8, 1'b0);
        conv_wait(20, 1'b0, 8'h00);
        ale_pulse(3'd0);
        checks++;
        if (eoc !== 1'b0) begin
            errs++;
            $display("FAIL abort_ale_eoc: got %b want 0", eoc);
        end
        do_start(8, 1'b1);
        conv_wait(CONV, 1'b0, 8'h00);
        check_result("abort");
    endtask

    task automatic test_reset_mid();
        ale_pulse(3'd6);
        do_start(4, 1'b0);
        conv_wait(30, 1'b0, 8'h00);
        reset  = 1'b0;
        out_en = 1'b1;
        #1;
        checks++;
        if (eoc !== 1'b1 || result !== 8'h00) begin
            errs++;
            $display("FAIL reset_mid: got eoc=%b result=%h want 1/00", eoc, result);
        end
        tick();
        reset    = 1'b1;
        m_result = 8'h00;
        m_addr   = 3'd0;
        tick();
        ch[2] = 8'($urandom);
        drive_ch();
        ale_pulse(3'd2);
        do_start(6, 1'b0);
        conv_wait(CONV, 1'b0, 8'h00);
        check_result("after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) ch[i] = 8'($urandom);
            drive_ch();
            ale_pulse(3'($urandom_range(0, 7)));
            do_start($urandom_range(1, 10), 1'b0);
            conv_wait(CONV, 1'b0, 8'h00);
            check_result("random");
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_sample_hold();
        test_short_start();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
